// File: rtl/aes_strm_sink_pkg.sv
// rtl/aes_strm_sink_pkg.sv - shared types and constants for the AES stream sink
//
// Purpose: state enum, soft register map, status bit positions, stream
//          geometry and the 512-to-64 lane fold helper.
// Ports:   none (package).
package aes_strm_sink_pkg;

    localparam int LANES     = 8;
    localparam int LANE_W    = 64;
    localparam int TDATA_W   = LANES * LANE_W;
    localparam int TDEST_W   = 5;
    localparam int SR_ADDR_W = 32;
    localparam int SR_DATA_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Write-side register addresses
    localparam logic [6:0] ADDR_START    = 7'h00;
    localparam logic [6:0] ADDR_ABORT    = 7'h08;
    // Read-side register addresses
    localparam logic [6:0] ADDR_ACCEPTED = 7'h00;
    localparam logic [6:0] ADDR_REMAIN   = 7'h08;
    localparam logic [6:0] ADDR_DIGEST   = 7'h10;
    localparam logic [6:0] ADDR_STATUS   = 7'h18;
    localparam logic [6:0] ADDR_PKTS     = 7'h20;
    localparam logic [6:0] ADDR_CYCLES   = 7'h28;
    localparam logic [6:0] ADDR_THROTTLE = 7'h30;

    // Status word layout
    localparam int STAT_STATE_LSB  = 0;
    localparam int STAT_OVF_BIT    = 2;
    localparam int STAT_TMO_BIT    = 3;
    localparam int STAT_DEST_LSB   = 8;
    localparam int STAT_OVFCNT_LSB = 16;

    typedef struct packed {
        logic                 valid;
        logic                 isWrite;
        logic [SR_ADDR_W-1:0] addr;
        logic [SR_DATA_W-1:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic                 valid;
        logic [SR_DATA_W-1:0] data;
    } SoftRegResp;

    // XOR of all 64-bit lanes of one beat
    function automatic logic [LANE_W-1:0] lane_fold(input logic [TDATA_W-1:0] data);
        logic [LANE_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < LANES; i++) begin
            acc ^= data[i*LANE_W +: LANE_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/axi_stream_t.sv
// rtl/axi_stream_t.sv - user-side virtual stream interface
//
// Purpose: bundles tdata/tdest/tlast/tvalid/tready of one stream.
// Ports:   master drives tdata, tdest, tlast, tvalid and samples tready;
//          slave is the mirror image.
interface axi_stream_t #(
    parameter int DATA_W = 512,
    parameter int DEST_W = 5
);
    logic [DATA_W-1:0] tdata;
    logic [DEST_W-1:0] tdest;
    logic              tlast;
    logic              tvalid;
    logic              tready;

    modport master (output tdata, output tdest, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tdest, input tlast, input tvalid, output tready);
endinterface

// File: rtl/aes_strm_sink_strm_digest.sv
// rtl/aes_strm_sink_strm_digest.sv - lane fold and rotate-xor digest accumulator
//
// Purpose: folds each 512-bit beat to 64 bits and accumulates it as
//          digest <= rotl1(digest) ^ fold.
// Ports:   clk, rst    clock, async active-high reset
//          clr_i       zero the digest (wins over en_i)
//          en_i        accumulate tdata_i this cycle
//          tdata_i     512-bit beat
//          digest_o    current digest
module strm_digest
    import aes_strm_sink_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               en_i,
    input  logic [TDATA_W-1:0] tdata_i,
    output logic [LANE_W-1:0]  digest_o
);

    logic [LANE_W-1:0] digest_q;
    logic [LANE_W-1:0] digest_d;

    always_comb begin
        digest_d = digest_q;
        if (clr_i) begin
            digest_d = '0;
        end else if (en_i) begin
            digest_d = {digest_q[LANE_W-2:0], digest_q[LANE_W-1]} ^ lane_fold(tdata_i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digest_q <= '0;
        end else begin
            digest_q <= digest_d;
        end
    end

    assign digest_o = digest_q;

endmodule

// File: rtl/aes_strm_sink.sv
// rtl/aes_strm_sink.sv - AES stream sink: beat/packet counting, digest, watchdog
//
// Purpose: terminates the user-side stream, counts beats against a host
//          programmed expectation, folds data into a 64-bit digest and
//          exposes results through the soft register interface.
// Ports:   clk, rst       clock, async active-high reset
//          softreg_req    soft register request (valid, isWrite, addr, data)
//          softreg_resp   read response, one cycle after the read strobe
//          axis_s         incoming 512-bit stream; this block drives tready
// Option:  STRM_SINK_THROTTLE_EN adds register 0x30 (T) which inserts one
//          tready=0 cycle after every T ready cycles.
module aes_strm_sink
    import aes_strm_sink_pkg::*;
#(
    parameter int TIMEOUT_LOG = 20,
    parameter int CNT_W       = 34
) (
    input  logic       clk,
    input  logic       rst,
    input  SoftRegReq  softreg_req,
    output SoftRegResp softreg_resp,
    axi_stream_t.slave axis_s
);

    // Watchdog saturates at exactly 2^TIMEOUT_LOG
    localparam logic [TIMEOUT_LOG:0] IDLE_MAX = {1'b1, {TIMEOUT_LOG{1'b0}}};

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     exp_q, exp_d;
    logic [CNT_W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]     pkts_q, pkts_d;
    logic [63:0]          cyc_q, cyc_d;
    logic [TIMEOUT_LOG:0] idle_q, idle_d;
    logic                 ovf_q, ovf_d;
    logic                 tmo_q, tmo_d;
    logic [15:0]          ovf_cnt_q, ovf_cnt_d;
    logic [TDEST_W-1:0]   dest_q, dest_d;
    logic                 rvalid_q;
    logic [63:0]          rdata_q, rdata_d;

    logic                 wr;
    logic                 wr_start;
    logic                 wr_abort;
    logic                 rd_req;
    logic                 active;
    logic                 tready;
    logic                 beat;
    logic                 dig_en;
    logic [63:0]          digest;
    logic [63:0]          status;
    logic                 unused_bits;

    assign wr       = softreg_req.valid && softreg_req.isWrite;
    assign wr_start = wr && (softreg_req.addr[6:0] == ADDR_START);
    assign wr_abort = wr && (softreg_req.addr[6:0] == ADDR_ABORT);
    assign rd_req   = softreg_req.valid && !softreg_req.isWrite;
    assign active   = (state_q != ST_IDLE);
    assign beat     = axis_s.tvalid && tready;

    // Only addr[6:0] and data[CNT_W-1:0] carry meaning
    assign unused_bits = ^{softreg_req.addr, softreg_req.data};

`ifdef STRM_SINK_THROTTLE_EN
    logic       wr_thr;
    logic [7:0] thr_t_q, thr_t_d;
    logic [7:0] thr_run_q, thr_run_d;
    logic       thr_block;

    assign wr_thr    = wr && (softreg_req.addr[6:0] == ADDR_THROTTLE);
    // After T consecutive ready cycles, drop tready for one cycle
    assign thr_block = (thr_t_q != 8'd0) && (thr_run_q >= thr_t_q);
    assign tready    = active && !thr_block;
    assign thr_run_d = (tready && (thr_t_q != 8'd0)) ? thr_run_q + 8'd1 : 8'd0;
    assign thr_t_d   = wr_thr ? softreg_req.data[7:0] : thr_t_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_t_q   <= 8'd0;
            thr_run_q <= 8'd0;
        end else begin
            thr_t_q   <= thr_t_d;
            thr_run_q <= thr_run_d;
        end
    end
`else
    assign tready = active;
`endif

    assign axis_s.tready = tready;

    // Overflow beats in DONE are consumed but never folded
    assign dig_en = beat && (state_q == ST_RUN) && !wr_start;

    strm_digest u_digest (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (wr_start),
        .en_i     (dig_en),
        .tdata_i  (axis_s.tdata),
        .digest_o (digest)
    );

    // Next-state and counter update; a start write overrides any beat
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        acc_d     = acc_q;
        pkts_d    = pkts_q;
        cyc_d     = cyc_q;
        idle_d    = idle_q;
        ovf_d     = ovf_q;
        tmo_d     = tmo_q;
        ovf_cnt_d = ovf_cnt_q;
        dest_d    = dest_q;

        if (wr_start) begin
            exp_d     = softreg_req.data[CNT_W-1:0];
            acc_d     = '0;
            pkts_d    = '0;
            cyc_d     = '0;
            idle_d    = '0;
            ovf_d     = 1'b0;
            tmo_d     = 1'b0;
            ovf_cnt_d = '0;
            dest_d    = '0;
            state_d   = (softreg_req.data[CNT_W-1:0] == '0) ? ST_DONE : ST_RUN;
        end else begin
            if (beat && (state_q == ST_RUN)) begin
                acc_d = acc_q + CNT_W'(1);
                if (axis_s.tlast) begin
                    pkts_d = pkts_q + CNT_W'(1);
                    dest_d = axis_s.tdest;
                end
                if (acc_q + CNT_W'(1) == exp_q) begin
                    state_d = ST_DONE;
                end
            end
            if (beat && (state_q == ST_DONE)) begin
                ovf_d = 1'b1;
                if (ovf_cnt_q != 16'hFFFF) begin
                    ovf_cnt_d = ovf_cnt_q + 16'd1;
                end
            end
            if (state_q == ST_RUN) begin
                cyc_d = cyc_q + 64'd1;
                if (beat) begin
                    idle_d = '0;
                end else if (idle_q != IDLE_MAX) begin
                    idle_d = idle_q + (TIMEOUT_LOG+1)'(1);
                end
                if (idle_d == IDLE_MAX) begin
                    tmo_d = 1'b1;
                end
            end
            if (wr_abort) begin
                state_d = ST_IDLE;
            end
        end
    end

    always_comb begin
        status = '0;
        status[STAT_OVFCNT_LSB +: 16]    = ovf_cnt_q;
        status[STAT_DEST_LSB +: TDEST_W] = dest_q;
        status[STAT_TMO_BIT]             = tmo_q;
        status[STAT_OVF_BIT]             = ovf_q;
        status[STAT_STATE_LSB +: 2]      = state_q;
    end

    // Read mux samples pre-update register values
    always_comb begin
        rdata_d = '0;
        if (rd_req) begin
            case (softreg_req.addr[6:0])
                ADDR_ACCEPTED: rdata_d = 64'(acc_q);
                ADDR_REMAIN:   rdata_d = (state_q == ST_RUN) ? 64'(exp_q - acc_q) : 64'd0;
                ADDR_DIGEST:   rdata_d = digest;
                ADDR_STATUS:   rdata_d = status;
                ADDR_PKTS:     rdata_d = 64'(pkts_q);
                ADDR_CYCLES:   rdata_d = cyc_q;
`ifdef STRM_SINK_THROTTLE_EN
                ADDR_THROTTLE: rdata_d = 64'(thr_t_q);
`endif
                default:       rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            exp_q     <= '0;
            acc_q     <= '0;
            pkts_q    <= '0;
            cyc_q     <= '0;
            idle_q    <= '0;
            ovf_q     <= 1'b0;
            tmo_q     <= 1'b0;
            ovf_cnt_q <= '0;
            dest_q    <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            acc_q     <= acc_d;
            pkts_q    <= pkts_d;
            cyc_q     <= cyc_d;
            idle_q    <= idle_d;
            ovf_q     <= ovf_d;
            tmo_q     <= tmo_d;
            ovf_cnt_q <= ovf_cnt_d;
            dest_q    <= dest_d;
            rvalid_q  <= rd_req;
            rdata_q   <= rdata_d;
        end
    end

    assign softreg_resp.valid = rvalid_q;
    assign softreg_resp.data  = rdata_q;

endmodule

// File: tb/tb_aes_strm_sink.sv
// tb/tb_aes_strm_sink.sv - self-checking bench for aes_strm_sink
module tb_aes_strm_sink;
    import aes_strm_sink_pkg::*;

    localparam int TL = 4;
    localparam longint unsigned MASK34 = (64'd1 << 34) - 64'd1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    SoftRegReq  softreg_req = '0;
    SoftRegResp softreg_resp;
    axi_stream_t #(.DATA_W(512), .DEST_W(5)) axis ();

    int n_checks = 0;
    int n_fail   = 0;
    int n_print  = 0;

    always #5 clk = ~clk;

    aes_strm_sink #(.TIMEOUT_LOG(TL), .CNT_W(34)) dut (
        .clk          (clk),
        .rst          (rst),
        .softreg_req  (softreg_req),
        .softreg_resp (softreg_resp),
        .axis_s       (axis)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_print < 40) begin
                n_print++;
                $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    int              m_state;   // 0 idle, 1 run, 2 done
    longint unsigned m_E, m_acc, m_pkts, m_cyc;
    logic [63:0]     m_dig;
    bit              m_ovf, m_tmo;
    int              m_ovfcnt, m_idle, m_dest, m_T, m_run;
    bit              m_rv;
    logic [63:0]     m_rd;

    task automatic m_reset();
        m_state = 0; m_E = 0; m_acc = 0; m_pkts = 0; m_cyc = 0; m_dig = '0;
        m_ovf = 0; m_tmo = 0; m_ovfcnt = 0; m_idle = 0; m_dest = 0;
        m_T = 0; m_run = 0; m_rv = 0; m_rd = '0;
    endtask

    function automatic bit m_tready();
        return (m_state != 0) && !(m_T != 0 && m_run >= m_T);
    endfunction

    function automatic logic [63:0] m_read(input int a);
        logic [63:0] s;
        s = '0;
        case (a)
            'h00: s = m_acc;
            'h08: s = (m_state == 1) ? m_E - m_acc : 64'd0;
            'h10: s = m_dig;
            'h18: begin
                s[31:16] = m_ovfcnt[15:0];
                s[12:8]  = m_dest[4:0];
                s[3]     = m_tmo;
                s[2]     = m_ovf;
                s[1:0]   = m_state[1:0];
            end
            'h20: s = m_pkts;
            'h28: s = m_cyc;
`ifdef STRM_SINK_THROTTLE_EN
            'h30: s = 64'(m_T);
`endif
            default: s = '0;
        endcase
        return s;
    endfunction

    task automatic m_step();
        bit          rdy, acc, wr;
        int          a, old;
        logic [63:0] f;
        rdy = m_tready();
        acc = axis.tvalid && rdy;
        a   = int'(softreg_req.addr[6:0]);
        wr  = softreg_req.valid && softreg_req.isWrite;
        old = m_state;
        m_rv = softreg_req.valid && !softreg_req.isWrite;
        m_rd = m_rv ? m_read(a) : 64'd0;
        if (m_T == 0 || !rdy) m_run = 0; else m_run++;
        if (wr && a == 'h00) begin
            m_E = softreg_req.data & MASK34;
            m_acc = 0; m_pkts = 0; m_cyc = 0; m_idle = 0; m_dig = '0;
            m_ovf = 0; m_tmo = 0; m_ovfcnt = 0; m_dest = 0;
            m_state = (m_E == 0) ? 2 : 1;
        end else begin
            if (acc && old == 1) begin
                f = '0;
                for (int i = 0; i < 8; i++) f ^= axis.tdata[i*64 +: 64];
                m_dig = ((m_dig << 1) | (m_dig >> 63)) ^ f;
                m_acc++;
                if (axis.tlast) begin
                    m_pkts++;
                    m_dest = int'(axis.tdest);
                end
                if (m_acc == m_E) m_state = 2;
            end else if (acc && old == 2) begin
                m_ovf = 1;
                if (m_ovfcnt < 65535) m_ovfcnt++;
            end
            if (old == 1) begin
                m_cyc++;
                if (acc) m_idle = 0;
                else if (m_idle < (1 << TL)) m_idle++;
                if (m_idle == (1 << TL)) m_tmo = 1;
            end
            if (wr && a == 'h08) m_state = 0;
        end
`ifdef STRM_SINK_THROTTLE_EN
        if (wr && a == 'h30) m_T = int'(softreg_req.data[7:0]);
`endif
    endtask

    // Compare outputs mid-cycle, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        if (rst) m_reset();
        chk("tready", 64'(axis.tready), 64'(m_tready()));
        chk("resp_valid", 64'(softreg_resp.valid), 64'(m_rv));
        if (m_rv) chk("resp_data", softreg_resp.data, m_rd);
        if (!rst) m_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sr_write(input logic [6:0] a, input logic [63:0] d);
        softreg_req.valid   = 1'b1;
        softreg_req.isWrite = 1'b1;
        softreg_req.addr    = {25'd0, a};
        softreg_req.data    = d;
        tick(1);
        softreg_req = '0;
    endtask

    task automatic sr_read(input logic [6:0] a, output logic [63:0] d);
        softreg_req.valid   = 1'b1;
        softreg_req.isWrite = 1'b0;
        softreg_req.addr    = {25'd0, a};
        softreg_req.data    = '0;
        tick(1);
        d = softreg_resp.data;
        softreg_req = '0;
    endtask

    task automatic send_beat(input logic [511:0] d, input logic last, input logic [4:0] dest);
        bit got;
        axis.tvalid = 1'b1;
        axis.tdata  = d;
        axis.tlast  = last;
        axis.tdest  = dest;
        got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            got = axis.tready;
            tick(1);
        end
        axis.tvalid = 1'b0;
        axis.tlast  = 1'b0;
        chk("beat_accept_bound", 64'(got), 64'd1);
    endtask

    task automatic rand_data(output logic [511:0] d);
        for (int k = 0; k < 16; k++) d[k*32 +: 32] = $urandom();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [63:0]  rd;
        logic [511:0] d;
        axis.tvalid = 1'b0;
        axis.tdata  = '0;
        axis.tlast  = 1'b0;
        axis.tdest  = '0;
        rst = 1'b1;
        tick(3);
        chk("rst_tready", 64'(axis.tready), 64'd0);
        chk("rst_resp_valid", 64'(softreg_resp.valid), 64'd0);
        chk("rst_resp_data", softreg_resp.data, 64'd0);
        rst = 1'b0;
        tick(1);

        // four beats, folds all cancel
        sr_write(7'h00, 64'd4);
        send_beat({8{64'h1}}, 1'b0, 5'd0);
        send_beat({8{64'h2}}, 1'b0, 5'd0);
        send_beat('0, 1'b0, 5'd0);
        send_beat('0, 1'b1, 5'd5);
        sr_read(7'h18, rd);
        chk("t1_state", 64'(rd[1:0]), 64'd2);
        chk("t1_last_dest", 64'(rd[12:8]), 64'd5);
        sr_read(7'h00, rd);
        chk("t1_accepted", rd, 64'd4);
        sr_read(7'h20, rd);
        chk("t1_pkts", rd, 64'd1);
        sr_read(7'h10, rd);
        chk("t1_digest", rd, 64'd0);

        // single lane-0 beat
        sr_write(7'h00, 64'd1);
        send_beat(512'hA5, 1'b0, 5'd0);
        sr_read(7'h10, rd);
        chk("t2_digest", rd, 64'hA5);

        // overflow beat in DONE
        sr_write(7'h00, 64'd2);
        for (int i = 0; i < 3; i++) begin
            rand_data(d);
            chk("t3_tready", 64'(axis.tready), 64'd1);
            send_beat(d, 1'b0, 5'd0);
        end
        sr_read(7'h18, rd);
        chk("t3_ovf", 64'(rd[2]), 64'd1);
        chk("t3_ovf_cnt", 64'(rd[31:16]), 64'd1);
        sr_read(7'h00, rd);
        chk("t3_accepted", rd, 64'd2);

        // abort keeps counts, IDLE back-pressures
        sr_write(7'h08, 64'd0);
        axis.tvalid = 1'b1;
        axis.tdata  = 512'h77;
        for (int i = 0; i < 10; i++) begin
            chk("t4_idle_tready", 64'(axis.tready), 64'd0);
            tick(1);
        end
        sr_read(7'h00, rd);
        chk("t4_kept", rd, 64'd2);
        sr_write(7'h00, 64'd1);
        chk("t4_armed_tready", 64'(axis.tready), 64'd1);
        tick(1);
        axis.tvalid = 1'b0;
        sr_read(7'h00, rd);
        chk("t4_accepted", rd, 64'd1);

        // last beat and read of 0x00 in the same cycle
        sr_write(7'h00, 64'd2);
        send_beat(512'h3, 1'b0, 5'd0);
        axis.tvalid = 1'b1;
        axis.tdata  = 512'h4;
        sr_read(7'h00, rd);
        axis.tvalid = 1'b0;
        chk("t5_pre_update", rd, 64'd1);
        sr_read(7'h18, rd);
        chk("t5_state", 64'(rd[1:0]), 64'd2);

        // start write wins over a beat in the same cycle
        sr_write(7'h00, 64'd5);
        axis.tvalid = 1'b1;
        axis.tdata  = 512'h9;
        sr_write(7'h00, 64'd5);
        axis.tvalid = 1'b0;
        sr_read(7'h00, rd);
        chk("t6_write_wins", rd, 64'd0);

        // watchdog boundary
        sr_write(7'h00, 64'd8);
        tick(14);
        sr_read(7'h18, rd);
        chk("t7_tmo_before", 64'(rd[3]), 64'd0);
        tick(1);
        sr_read(7'h18, rd);
        chk("t7_tmo", 64'(rd[3]), 64'd1);
        chk("t7_state", 64'(rd[1:0]), 64'd1);

        // reset mid-run
        rst = 1'b1;
        tick(2);
        chk("t8_rst_tready", 64'(axis.tready), 64'd0);
        rst = 1'b0;
        for (int a = 0; a < 6; a++) begin
            sr_read(7'(a * 8), rd);
            chk("t8_reg_zero", rd, 64'd0);
        end

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int r;
            rst = ($urandom_range(0, 399) == 0);
            softreg_req = '0;
            r = $urandom_range(0, 99);
            if (r < 8) begin
                softreg_req.valid   = 1'b1;
                softreg_req.isWrite = 1'b1;
                softreg_req.addr    = {$urandom_range(0, 1) == 0 ? 25'd0 : 25'($urandom()), 7'h00};
                softreg_req.data    = ($urandom_range(0, 9) == 0) ? {$urandom(), $urandom()}
                                                                   : 64'($urandom_range(0, 6));
            end else if (r < 10) begin
                softreg_req.valid   = 1'b1;
                softreg_req.isWrite = 1'b1;
                softreg_req.addr    = 32'h08;
            end else if (r < 13) begin
                softreg_req.valid   = 1'b1;
                softreg_req.isWrite = 1'b1;
                softreg_req.addr    = 32'h30;
                softreg_req.data    = {56'($urandom()), 8'($urandom_range(0, 4))};
            end else if (r < 40) begin
                softreg_req.valid   = 1'b1;
                softreg_req.addr    = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 127))
                                                                  : 32'($urandom_range(0, 7) * 8);
            end
            axis.tvalid = ($urandom_range(0, 9) < 7);
            rand_data(d);
            axis.tdata = d;
            axis.tlast = ($urandom_range(0, 3) == 0);
            axis.tdest = 5'($urandom());
            tick(1);
        end
        rst = 1'b0;
        softreg_req = '0;
        axis.tvalid = 1'b0;
        tick(2);

`ifdef STRM_SINK_THROTTLE_EN
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        sr_write(7'h30, 64'd3);
        sr_write(7'h00, 64'd1000);
        axis.tvalid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            chk("thr_pattern", 64'(axis.tready), 64'((i % 4) != 3));
            tick(1);
        end
        axis.tvalid = 1'b0;
        sr_read(7'h00, rd);
        chk("thr_accepted", rd, 64'd30);
`endif

        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
